// File: rtl/exposure_timer.sv
// Sensor-side exposure timer: gates Expose for exactly T ticks of Counter_Clk after a Start request.
// Optional input clamping of the requested time is enabled by defining EXPOSURE_CLAMP_EN.
module exposure_timer #(
   parameter int WIDTH   = 5,
   parameter int EXP_MIN = 2,
   parameter int EXP_MAX = 30
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             Counter_Clk,
   input  logic             Counter_Reset,
   input  logic [WIDTH-1:0] Exp_Time,
   input  logic             Start,
   output logic             Expose,
   output logic             Busy,
   output logic             Done,
   output logic             Aborted,
   output logic [WIDTH-1:0] Count
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ARMED  = 2'd1;
   localparam logic [1:0] S_EXPOSE = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

`ifdef EXPOSURE_CLAMP_EN
   localparam bit CLAMP_EN = 1'b1;
`else
   localparam bit CLAMP_EN = 1'b0;
`endif

   localparam logic [WIDTH-1:0] MIN_T = WIDTH'(EXP_MIN);
   localparam logic [WIDTH-1:0] MAX_T = WIDTH'(EXP_MAX);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] t_q, t_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             aborted_q, aborted_d;
   logic [WIDTH-1:0] t_clamped;
   logic [WIDTH-1:0] t_sel;

   always_comb begin
      t_clamped = Exp_Time;
      if (t_clamped > MAX_T) t_clamped = MAX_T;
      if (t_clamped < MIN_T) t_clamped = MIN_T;
   end

   assign t_sel = CLAMP_EN ? t_clamped : Exp_Time;

   always_comb begin
      state_d   = state_q;
      t_d       = t_q;
      count_d   = count_q;
      aborted_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (Start && !Counter_Reset) begin
               t_d     = t_sel;
               count_d = '0;
               state_d = S_ARMED;
            end
         end
         S_ARMED: begin
            if (Counter_Reset) begin
               count_d   = '0;
               aborted_d = 1'b1;
               state_d   = S_IDLE;
            end else if (Counter_Clk) begin
               // Exposure starts on a tick edge so every tick counted is a full one.
               count_d = '0;
               state_d = (t_q == '0) ? S_DONE : S_EXPOSE;
            end
         end
         S_EXPOSE: begin
            // An abort wins over a coincident final tick.
            if (Counter_Reset) begin
               count_d   = '0;
               aborted_d = 1'b1;
               state_d   = S_IDLE;
            end else if (Counter_Clk) begin
               count_d = count_q + WIDTH'(1);
               if (count_q == t_q - WIDTH'(1)) state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (Counter_Reset) count_d = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q   <= S_IDLE;
         t_q       <= '0;
         count_q   <= '0;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         t_q       <= t_d;
         count_q   <= count_d;
         aborted_q <= aborted_d;
      end
   end

   assign Expose  = (state_q == S_EXPOSE);
   assign Busy    = (state_q != S_IDLE);
   assign Done    = (state_q == S_DONE);
   assign Aborted = aborted_q;
   assign Count   = count_q;

endmodule

// File: tb/tb_exposure_timer.sv
// Scoreboard bench for exposure_timer: each accepted exposure pushes its expected outcome,
// which is popped and compared when the DUT pulses Done or Aborted.
module tb_exposure_timer;
   localparam int W = 5;

   logic         clk = 1'b0;
   logic         rst_n, cclk, crst, start;
   logic [W-1:0] exp_time;
   logic         expose, busy, done, aborted;
   logic [W-1:0] count;

   always #5 clk = ~clk;

   exposure_timer #(.WIDTH(W)) dut (
      .Clk          (clk),
      .Reset_n      (rst_n),
      .Counter_Clk  (cclk),
      .Counter_Reset(crst),
      .Exp_Time     (exp_time),
      .Start        (start),
      .Expose       (expose),
      .Busy         (busy),
      .Done         (done),
      .Aborted      (aborted),
      .Count        (count)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", tag, act, req);
      end
   endtask

   typedef struct {
      bit is_abort;
      int ticks;
      int cycles;
      int cnt;
   } sb_item_t;

   sb_item_t sb[$];

   int tick_period = 1;
   int phase = 0;

   function automatic int eff_t(input int e);
`ifdef EXPOSURE_CLAMP_EN
      if (e < 2) return 2;
      if (e > 30) return 30;
`endif
      return e;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      phase++;
      if (phase >= tick_period) phase = 0;
      cclk = (phase == 0);
   endtask

   task automatic set_period(input int p);
      tick_period = p;
      phase = 0;
   endtask

   task automatic start_exp(input int e, input bit ab);
      sb_item_t it;
      int t;
      t = eff_t(e);
      exp_time = W'(e);
      start = 1'b1;
      step();
      start = 1'b0;
      it.is_abort = ab;
      it.ticks    = t;
      it.cycles   = t * tick_period;
      it.cnt      = t;
      sb.push_back(it);
      $display("txn start exp_time=%0d eff=%0d period=%0d abort_expected=%0d", e, t, tick_period, ab);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy && n < 2000) begin
         step();
         n++;
      end
      if (busy) chk({tag, "_timeout"}, 1, 0);
   endtask

   task automatic wait_expose_count(input int c, input string tag);
      int n = 0;
      while (!(expose && count == W'(c)) && n < 500) begin
         step();
         n++;
      end
      if (!(expose && count == W'(c))) chk({tag, "_timeout"}, 1, 0);
   endtask

   // Monitor: per-cycle Count tracking and scoreboard pops on completion pulses.
   int ticks_seen = 0;
   int cycles_seen = 0;
   bit prev_done = 1'b0;

   always @(negedge clk) begin
      sb_item_t e;
      if (!rst_n) begin
         ticks_seen  = 0;
         cycles_seen = 0;
         prev_done   = 1'b0;
      end else begin
         if (prev_done) begin
            chk("done_one_cycle", done, 0);
            chk("busy_after_done", busy, 0);
         end
         prev_done = done;
         if (expose) begin
            chk("count_running", count, ticks_seen);
            cycles_seen++;
            if (cclk) ticks_seen++;
         end
         if (done || aborted) begin
            if (sb.size() == 0) begin
               chk("unexpected_pulse", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("aborted_flag", aborted, e.is_abort);
               chk("done_flag", done, !e.is_abort);
               chk("expose_low_at_end", expose, 0);
               if (!e.is_abort) begin
                  chk("expose_ticks", ticks_seen, e.ticks);
                  chk("expose_cycles", cycles_seen, e.cycles);
                  chk("done_count", count, e.cnt);
               end else begin
                  chk("abort_count", count, 0);
               end
               $display("txn end done=%0d aborted=%0d ticks=%0d cycles=%0d count=%0d",
                        done, aborted, ticks_seen, cycles_seen, count);
            end
         end
         if (!busy) begin
            ticks_seen  = 0;
            cycles_seen = 0;
         end
      end
   end

   initial begin
      int n;
      sb_item_t it;
      rst_n = 1'b0; cclk = 1'b0; crst = 1'b0; start = 1'b0; exp_time = '0;
      @(posedge clk); @(posedge clk); #1;
      chk("rst_expose", expose, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_aborted", aborted, 0);
      chk("rst_count", count, 0);
      rst_n = 1'b1;
      step();

      // Tick every cycle, 3-tick exposure.
      set_period(1);
      start_exp(3, 0);
      wait_idle("t3");
      step();

      // Tick every 4th cycle, 2-tick exposure spans 8 cycles.
      set_period(4);
      start_exp(2, 0);
      wait_idle("t2p4");
      step();

      // Abort on the 4th tick of a 6-tick exposure.
      set_period(1);
      start_exp(6, 1);
      wait_expose_count(3, "abort4");
      crst = 1'b1;
      step();
      crst = 1'b0;
      chk("abort4_pulse", aborted, 1);
      chk("abort4_expose", expose, 0);
      wait_idle("abort4");
      step();

      // Abort coincident with the final tick.
      start_exp(6, 1);
      wait_expose_count(5, "abort6");
      crst = 1'b1;
      step();
      crst = 1'b0;
      chk("abort6_done", done, 0);
      wait_idle("abort6");
      step();

      // Start re-pulsed mid-exposure with a new time has no effect.
      start_exp(4, 0);
      wait_expose_count(2, "restart");
      exp_time = W'(9);
      start = 1'b1;
      step();
      start = 1'b0;
      wait_idle("restart");
      step();

      // Boundary exposure times.
      start_exp(0, 0);
      wait_idle("t0");
      step();
      start_exp(31, 0);
      wait_idle("t31");
      step();

      // Start held high: back-to-back with one idle cycle between.
      exp_time = W'(2);
      start = 1'b1;
      step();
      it.is_abort = 0; it.ticks = 2; it.cycles = 2; it.cnt = 2;
      sb.push_back(it);
      n = 0;
      while (!done && n < 200) begin step(); n++; end
      chk("b2b_first_done", done, 1);
      step();
      chk("b2b_idle_gap", busy, 0);
      step();
      chk("b2b_reaccept", busy, 1);
      sb.push_back(it);
      start = 1'b0;
      wait_idle("b2b");
      step();

      // Counter_Reset while in DONE: Done still pulses, Count cleared.
      start_exp(2, 0);
      n = 0;
      while (!done && n < 200) begin step(); n++; end
      crst = 1'b1;
      step();
      crst = 1'b0;
      chk("done_clr_count", count, 0);
      chk("done_clr_busy", busy, 0);
      chk("done_clr_aborted", aborted, 0);
      step();

      // Asynchronous reset in the middle of a 5-tick exposure.
      start_exp(5, 0);
      wait_expose_count(2, "rstmid");
      #2;
      rst_n = 1'b0;
      #1;
      sb.delete();
      chk("rstmid_expose", expose, 0);
      chk("rstmid_busy", busy, 0);
      chk("rstmid_count", count, 0);
      chk("rstmid_done", done, 0);
      chk("rstmid_aborted", aborted, 0);
      step();
      step();
      rst_n = 1'b1;
      step();
      step();
      chk("rstmid_idle", busy, 0);
      chk("rstmid_no_done", done, 0);

      chk("sb_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout actual=1 required=0");
      $fatal(1, "timeout");
   end
endmodule
